// File: rtl/fifo_rd_arb_pkg.sv
// fifo_rd_arb_pkg: shared types and constants for the FIFO read-side arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, GRANT)
//   IDX_W        : consumer index width for the default 4-consumer build
//   STATS_W      : width of the optional statistics counters
//   idx_width()  : index width for an arbitrary consumer count (min 1 bit)
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_REQ_DEF);
  localparam int unsigned STATS_W     = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req upward starting at last+1 (modulo NUM_REQ) and returns the
// first set bit both as a one-hot vector and as an index.
//   req  in  NUM_REQ  request vector
//   last in  IW       index granted most recently
//   pick out NUM_REQ  one-hot winner (all zero when req is zero)
//   idx  out IW       index of the winner (zero when req is zero)
module rr_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IW      = IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Offsets 1..NUM_REQ visit every consumer once, last itself at the end.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(last) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter sharing one FIFO read port among NUM_REQ
// consumers. Each grant allows at most BURST_LEN pops; read data is returned
// to the granted consumer two cycles after its pop with a one-hot valid.
//
// Ports:
//   rclk      in   read-domain clock (posedge)
//   rrst      in   synchronous active-high reset
//   req       in   per-consumer request levels
//   rempty    in   FIFO empty flag
//   rdata     in   FIFO read data, valid the cycle after rinc
//   rinc      out  FIFO pop strobe (combinational)
//   gnt       out  registered one-hot grant, zero when idle
//   dout      out  registered read data
//   dvalid    out  registered one-hot owner of dout
//   busy      out  high while in GRANT
//   pop_cnt   out  (FIFO_RD_ARB_STATS_EN) wrapping count of rinc pulses
//   stall_cnt out  (FIFO_RD_ARB_STATS_EN) saturating count of req-while-empty cycles
//
// Optional feature macro: FIFO_RD_ARB_STATS_EN
module fifo_rd_arb
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [NUM_REQ-1:0]    dvalid,
  output logic                  busy
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]    pop_cnt,
  output logic [STATS_W-1:0]    stall_cnt
`endif
);

  localparam int unsigned IW  = idx_width(NUM_REQ);
  localparam int unsigned BCW = $clog2(BURST_LEN) + 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] p_oh;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      p_idx_q;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic               grant_live;
  logic               burst_done;
  logic               p_vld_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign busy = (state_q == GRANT);

  // Pop decision: granted consumer still requesting and data available.
  always_comb begin
    grant_live = |(gnt & req);
    rinc       = !rrst && (state_q == GRANT) && grant_live && !rempty;
    burst_done = rinc && (bcnt_q == BCW'(BURST_LEN - 1));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req && !rempty) begin
          state_d = GRANT;
          gnt_d   = pick;
          last_d  = pick_idx;
          bcnt_d  = '0;
        end
      end
      GRANT: begin
        if (rinc) begin
          bcnt_d = bcnt_q + 1'b1;
        end
        // All exit causes collapse into one release of the grant.
        if (burst_done || !grant_live || rempty) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      gnt     <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // While granted, last_q holds the granted index, so it tags the pop.
  always_comb begin
    p_oh          = '0;
    p_oh[p_idx_q] = 1'b1;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      p_vld_q <= 1'b0;
      p_idx_q <= '0;
      dout    <= '0;
      dvalid  <= '0;
    end else begin
      p_vld_q <= rinc;
      p_idx_q <= last_q;
      if (p_vld_q) begin
        dout   <= rdata;
        dvalid <= p_oh;
      end else begin
        dvalid <= '0;
      end
    end
  end

`ifdef FIFO_RD_ARB_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (rinc) begin
        pop_cnt <= pop_cnt + 1'b1;
      end
      if (|req && rempty && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_arb.sv
module tb_fifo_rd_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [NR-1:0] req;
  logic          rempty;
  logic [DW-1:0] rdata = '0;
  logic          rinc;
  logic [NR-1:0] gnt;
  logic [DW-1:0] dout;
  logic [NR-1:0] dvalid;
  logic          busy;
`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0]   pop_cnt, stall_cnt;
  logic          rrst_w;
  logic [1:0]    req_w;
  logic          rinc_w, busy_w;
  logic [1:0]    gnt_w, dvalid_w;
  logic [DW-1:0] dout_w;
  logic [15:0]   pop_cnt_w, stall_cnt_w;
  logic          rempty_w = 1'b0;
  logic [DW-1:0] rdata_w = '0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // FIFO model: data appears on rdata the cycle after a pop.
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  logic          flush  = 1'b0;

  assign rempty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rinc) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  always #5 rclk = ~rclk;

  fifo_rd_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .req       (req),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .gnt       (gnt),
    .dout      (dout),
    .dvalid    (dvalid),
    .busy      (busy)
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    .pop_cnt   (pop_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

`ifdef FIFO_RD_ARB_STATS_EN
  fifo_rd_arb #(
    .NUM_REQ    (2),
    .DATA_WIDTH (DW),
    .BURST_LEN  (65536)
  ) dut_w (
    .rclk      (rclk),
    .rrst      (rrst_w),
    .req       (req_w),
    .rempty    (rempty_w),
    .rdata     (rdata_w),
    .rinc      (rinc_w),
    .gnt       (gnt_w),
    .dout      (dout_w),
    .dvalid    (dvalid_w),
    .busy      (busy_w),
    .pop_cnt   (pop_cnt_w),
    .stall_cnt (stall_cnt_w)
  );
`endif

  // Underflow watch over the whole run.
  always @(negedge rclk) begin
    if (rinc) begin
      vectors++;
      if (rempty) begin
        miscompares++;
        $display("FAIL underflow: rinc=%b while rempty=%b", rinc, rempty);
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic apply_reset();
    rrst  = 1'b1;
    req   = '0;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    rrst  = 1'b0;
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    req  = 4'b1111;
    push(8'h77);
    step();
    #1;
    vectors++;
    if ({gnt, dvalid, dout, busy, rinc} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b dvalid=%b dout=%h busy=%b rinc=%b, required all zero",
               gnt, dvalid, dout, busy, rinc);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [3:0]    e_gnt  [10];
    logic          e_rinc [10];
    logic [3:0]    e_dv   [10];
    logic [DW-1:0] e_dout [10];
    e_gnt  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    e_rinc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_dv   = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    e_dout = '{8'h00, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA4, 8'hA5, 8'hA5};
    apply_reset();
    req = 4'b0001;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    #1;
    vectors++;
    if (gnt !== 4'h0 || rinc !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c0: gnt=%b rinc=%b, required 0000/0", gnt, rinc);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      #1;
      vectors++;
      if (gnt !== e_gnt[c] || rinc !== e_rinc[c] || dvalid !== e_dv[c] ||
          dout !== e_dout[c] || busy !== (e_gnt[c] != 4'h0)) begin
        miscompares++;
        $display("FAIL single_c%0d: gnt=%b rinc=%b dvalid=%b dout=%h busy=%b, required %b %b %b %h %b",
                 c + 1, gnt, rinc, dvalid, dout, busy, e_gnt[c], e_rinc[c], e_dv[c], e_dout[c],
                 e_gnt[c] != 4'h0);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]    e_gnt, e_dv;
    logic          e_rinc;
    logic [DW-1:0] e_dout;
    int            n;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 24; i++) push(8'h10 + 8'(i));
    n      = 0;
    e_dout = 8'h00;
    for (int c = 1; c <= 23; c++) begin
      step();
      #1;
      // Each grant spans 4 pop cycles plus one idle cycle.
      e_rinc = ((c - 1) % 5) < 4;
      e_gnt  = e_rinc ? (4'b0001 << (((c - 1) / 5) % 4)) : 4'b0000;
      e_dv   = 4'b0000;
      if (c >= 3 && ((c - 3) % 5) < 4) begin
        e_dv   = 4'b0001 << (((c - 3) / 5) % 4);
        e_dout = 8'h10 + 8'(n);
        n++;
      end
      vectors++;
      if (gnt !== e_gnt || rinc !== e_rinc || dvalid !== e_dv || dout !== e_dout) begin
        miscompares++;
        $display("FAIL rr_c%0d: gnt=%b rinc=%b dvalid=%b dout=%h, required %b %b %b %h",
                 c, gnt, rinc, dvalid, dout, e_gnt, e_rinc, e_dv, e_dout);
      end
    end
  endtask

  task automatic test_empty_stall();
    logic [3:0] e_gnt  [5];
    logic       e_rinc [5];
    logic [3:0] e_dv   [5];
    e_gnt  = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    e_rinc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_dv   = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    apply_reset();
    req = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      step();
      #1;
      vectors++;
      if (gnt !== 4'h0 || rinc !== 1'b0 || busy !== 1'b0 || dvalid !== 4'h0) begin
        miscompares++;
        $display("FAIL stall_c%0d: gnt=%b rinc=%b busy=%b dvalid=%b, required 0000 0 0 0000",
                 c, gnt, rinc, busy, dvalid);
      end
    end
    step();
    push(8'h5A);
    #1;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      vectors++;
      if (gnt !== e_gnt[c] || rinc !== e_rinc[c] || dvalid !== e_dv[c] ||
          (e_dv[c] != 4'h0 && dout !== 8'h5A)) begin
        miscompares++;
        $display("FAIL stall_w%0d: gnt=%b rinc=%b dvalid=%b dout=%h, required %b %b %b 5a",
                 c, gnt, rinc, dvalid, dout, e_gnt[c], e_rinc[c], e_dv[c]);
      end
    end
  endtask

  task automatic test_req_drop();
    logic [3:0]    e_gnt  [6];
    logic          e_rinc [6];
    logic [3:0]    e_dv   [6];
    logic [DW-1:0] e_dout [6];
    e_gnt  = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8};
    e_rinc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    e_dv   = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
    e_dout = '{8'h00, 8'h00, 8'h30, 8'h31, 8'h31, 8'h31};
    apply_reset();
    req = 4'b1100;
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 2) req = 4'b1000;
      #1;
      vectors++;
      if (gnt !== e_gnt[c] || rinc !== e_rinc[c] || dvalid !== e_dv[c] || dout !== e_dout[c]) begin
        miscompares++;
        $display("FAIL drop_c%0d: gnt=%b rinc=%b dvalid=%b dout=%h, required %b %b %b %h",
                 c + 1, gnt, rinc, dvalid, dout, e_gnt[c], e_rinc[c], e_dv[c], e_dout[c]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    step();
    #1;
    vectors++;
    if (gnt !== 4'h1 || rinc !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_c1: gnt=%b rinc=%b, required 0001 1", gnt, rinc);
    end
    step();
    rrst = 1'b1;
    #1;
    vectors++;
    if (rinc !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_rinc_in_reset: rinc=%b, required 0", rinc);
    end
    step();
    rrst = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'h0 || dvalid !== 4'h0 || busy !== 1'b0 || dout !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_after: gnt=%b dvalid=%b busy=%b dout=%h, required 0000 0000 0 00",
               gnt, dvalid, busy, dout);
    end
    step();
    #1;
    vectors++;
    if (gnt !== 4'h1 || dvalid !== 4'h0) begin
      miscompares++;
      $display("FAIL rmid_regrant: gnt=%b dvalid=%b, required 0001 0000", gnt, dvalid);
    end
    step();
    #1;
    vectors++;
    if (dvalid !== 4'h0) begin
      miscompares++;
      $display("FAIL rmid_no_stale: dvalid=%b, required 0000", dvalid);
    end
    step();
    #1;
    vectors++;
    if (dvalid !== 4'h1 || dout !== 8'h41) begin
      miscompares++;
      $display("FAIL rmid_data: dvalid=%b dout=%h, required 0001 41", dvalid, dout);
    end
  endtask

`ifdef FIFO_RD_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    req = 4'b0001;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 16) req = 4'b0000;
      #1;
      if (c == 5) begin
        vectors++;
        if (pop_cnt !== 16'd4) begin
          miscompares++;
          $display("FAIL stats_pop_mid: pop_cnt=%0d, required 4", pop_cnt);
        end
      end
      if (c == 17) begin
        vectors++;
        if (pop_cnt !== 16'd10 || stall_cnt !== 16'd3) begin
          miscompares++;
          $display("FAIL stats_final: pop_cnt=%0d stall_cnt=%0d, required 10 3",
                   pop_cnt, stall_cnt);
        end
      end
    end
  endtask

  task automatic test_pop_wrap();
    rrst_w = 1'b1;
    req_w  = 2'b00;
    step();
    step();
    rrst_w = 1'b0;
    req_w  = 2'b01;
    for (int c = 1; c <= 65539; c++) begin
      step();
      #1;
      if (c == 101) begin
        vectors++;
        if (pop_cnt_w !== 16'd100) begin
          miscompares++;
          $display("FAIL wrap_mid: pop_cnt=%0d, required 100", pop_cnt_w);
        end
      end
      if (c == 65537) begin
        vectors++;
        if (pop_cnt_w !== 16'd0 || stall_cnt_w !== 16'd0 || busy_w !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_zero: pop_cnt=%0d stall_cnt=%0d busy=%b, required 0 0 0",
                   pop_cnt_w, stall_cnt_w, busy_w);
        end
      end
      if (c == 65539) begin
        vectors++;
        if (pop_cnt_w !== 16'd1) begin
          miscompares++;
          $display("FAIL wrap_next: pop_cnt=%0d, required 1", pop_cnt_w);
        end
      end
    end
  endtask
`endif

  initial begin
    rrst = 1'b1;
    req  = '0;
`ifdef FIFO_RD_ARB_STATS_EN
    rrst_w = 1'b1;
    req_w  = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_empty_stall();
    test_req_drop();
    test_reset_mid_burst();
`ifdef FIFO_RD_ARB_STATS_EN
    test_stats();
    test_pop_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arb.md
Name: fifo_rd_arb

Overview:
- Round-robin read-side arbiter that shares one FIFO read port among NUM_REQ consumers.
- Drives the FIFO read-pointer block's rinc and consumes its rempty flag.
- Captures the FIFO memory read data and steers it, with a one-hot valid, to the granted consumer.
- Each grant covers a bounded burst of pops so no consumer can starve the others.

Parameters:
- NUM_REQ, 4, number of consumers (>=2).
- DATA_WIDTH, 8, FIFO data width.
- BURST_LEN, 4, maximum pops per grant (>=1).

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-consumer request level; held while the consumer wants data.
- rempty  in  1  FIFO empty flag from the read-pointer block.
- rdata  in  DATA_WIDTH  FIFO memory read data; valid the cycle after rinc.
- rinc  out  1  FIFO pop strobe (combinational).
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle.
- dout  out  DATA_WIDTH  registered data to consumers.
- dvalid  out  NUM_REQ  registered one-hot; the set bit owns dout that cycle.
- busy  out  1  high while state is GRANT.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, dvalid=0, dout=0, burst count=0, last-grant index=NUM_REQ-1 (so consumer 0 wins first), pipeline valids=0. rinc=0 in reset.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If |req and !rempty, pick the first set req searching upward from last+1, modulo NUM_REQ.
  - Next cycle: gnt gets that one-hot, last gets that index, burst count=0, state=GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - rinc = (state==GRANT) & |(gnt & req) & !rempty.
  - Each rinc increments the burst count.
- Exit GRANT to IDLE (gnt=0 next cycle) on any of:
  - rinc with burst count==BURST_LEN-1 (the burst completes);
  - granted req low;
  - rempty high.
- IDLE is always spent for at least one cycle between grants; the re-pick there gives round-robin fairness.
- Data pipeline, for rinc at cycle T:
  - T+1: stage registers capture the granted index and a pop valid.
  - T+2: dout=rdata (sampled at T+1) and dvalid=onehot(index); otherwise dvalid=0 and dout holds its value.
  - Pop-to-dvalid latency is 2 cycles. Back-to-back pops give back-to-back dvalid.
- In-flight data: pops already issued complete on dvalid even if the grant has been released or a new grant has started. Data is never dropped except on reset.
- Underflow: rinc is never asserted while rempty=1. If rempty rises in the same cycle as a pop decision, no pop occurs that cycle.
- Simultaneous events: a burst end and a req drop in the same cycle give a single exit. A new req arriving during GRANT waits for IDLE.
- Reset mid-operation: everything returns to reset values next edge, and pending pipeline data is discarded (dvalid=0).
- Burst count width is clog2(BURST_LEN)+1. The count never wraps, because it clears on every grant.

Optional Feature:
- Macro: FIFO_RD_ARB_STATS_EN.
- With the macro defined:
  - Adds output pop_cnt[15:0], a total count of rinc pulses, wrapping 16'hFFFF->0, cleared by rrst.
  - Adds output stall_cnt[15:0], counting cycles where |req and rempty, saturating at 16'hFFFF, cleared by rrst.
- Without the macro: neither port nor its logic exists, and the remaining behaviour is identical.

Decomposition:
- Package fifo_rd_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - localparam IDX_W = $clog2(NUM_REQ);
  - the STATS_W = 16 constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and last index.
  - Outputs: one-hot pick and index.
  - Instantiated once.

Test Plan:
- Reset then a single requester: NUM_REQ=4, BURST_LEN=4, req=4'b0001, FIFO holds 6 words.
  - gnt=0001 one cycle after req; 4 rinc pulses; one IDLE cycle; a second grant pops 2 words.
  - dvalid[0] pulses 6 times, each 2 cycles after its rinc, with data in FIFO order.
- Round-robin: req=4'b1111 held, FIFO deep.
  - Grant order 0,1,2,3,0; each grant gives exactly 4 pops; gnt is zero one cycle between grants.
- Empty stall: req=4'b0010 with the FIFO empty.
  - No gnt and rinc=0 throughout.
  - Writing 1 word gives a grant, 1 pop, then rempty releases the grant.
  - dvalid=0010 once.
- Request drop mid-burst: req[2] falls after 2 pops.
  - Exactly 2 rinc; grant released next cycle.
  - Both dvalid[2] pulses still appear; the next grant goes to the next requester above index 2.
- Reset mid-burst: assert rrst one cycle after a rinc.
  - Next edge: gnt=0, dvalid=0, busy=0, no dvalid for the in-flight pop.
  - After release, consumer 0 is granted first when req=1111.
- STATS (macro defined): 10 pops plus 3 empty-stall cycles give pop_cnt=10 and stall_cnt=3. Forcing 65536 pops gives pop_cnt=0.
